// File: rtl/bin_to_sseg_codes.sv
// Formats a binary value (iterative shift-add-3) or a fixed status word into
// 5-bit seven-segment symbol codes, one code per display digit.
module bin_to_sseg_codes #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 6
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   value,
  input  logic                    blank_zeros,
  output logic [5*DIGITS-1:0]     codes,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);
  localparam logic [4:0] SymOff = 5'd27;

  typedef enum logic [1:0] {StIdle, StConvert, StEmit} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [4*DIGITS-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    blank_q, blank_d;
  logic [5*DIGITS-1:0]     codes_q, codes_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Status words are right-justified; unused upper digits stay dark.
  function automatic logic [5*DIGITS-1:0] text_codes(input logic [1:0] m);
    logic [5*DIGITS-1:0] r;
    r = {DIGITS{SymOff}};
    unique case (m)
      2'd1:    r[14:0] = {5'd22, 5'd25, 5'd19};
      2'd2:    r[19:0] = {5'd13, 5'd20, 5'd19, 5'd14};
      2'd3:    r[19:0] = {5'd23, 5'd24, 5'd20, 5'd21};
      default: r = {DIGITS{SymOff}};
    endcase
    return r;
  endfunction

  // Digit 0 is never blanked so a zero value still shows "0".
  function automatic logic [5*DIGITS-1:0] number_codes(input logic [4*DIGITS-1:0] bcd,
                                                       input logic              bz);
    logic [5*DIGITS-1:0] r;
    logic                lead;
    logic [3:0]          nib;
    r    = '0;
    lead = bz;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = bcd[4*k +: 4];
      if (lead && nib == 4'd0 && k != 0) begin
        r[5*k +: 5] = SymOff;
      end else begin
        r[5*k +: 5] = {1'b0, nib};
        lead        = 1'b0;
      end
    end
    return r;
  endfunction

  always_comb begin
    logic [4*DIGITS-1:0] adj;
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    codes_d = codes_q;
    busy_d  = (state_q == StConvert);
    done_d  = 1'b0;
    adj     = bcd_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == 2'd0) begin
            shift_d = value;
            bcd_d   = '0;
            cnt_d   = '0;
            blank_d = blank_zeros;
            state_d = StConvert;
          end else begin
            codes_d = text_codes(mode);
            done_d  = 1'b1;
          end
        end
      end
      StConvert: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = StEmit;
      end
      StEmit: begin
        codes_d = number_codes(bcd_q, blank_q);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      codes_q <= {DIGITS{SymOff}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      codes_q <= codes_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign codes = codes_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
